// File: rtl/acsp_pkg.sv
// acsp_pkg: shared state types and sizing for the capture buffer.
// Imported by capture_buffer and its sample RAM.
package acsp_pkg;

  typedef enum logic [2:0] {
    CAP_IDLE,
    CAP_ARMED,
    CAP_POST,
    CAP_READ,
    CAP_WAIT_TX
  } cap_state_t;

  typedef enum logic [1:0] {
    RD_ISSUE,
    RD_LATCH,
    RD_SEND
  } rd_phase_t;

  localparam int DEF_SAMPLE_WIDTH = 8;
  localparam int DEF_DEPTH        = 1024;

  localparam int BYTES_PER_SAMPLE = (DEF_SAMPLE_WIDTH + 7) / 8;
  localparam int ADDR_W           = $clog2(DEF_DEPTH);

  function automatic int bytes_per(input int w);
    return (w + 7) / 8;
  endfunction

endpackage

// File: rtl/sample_ram.sv
// sample_ram: one write port, one registered read port.
// No reset so it maps onto block RAM.
module sample_ram
  import acsp_pkg::*;
#(
  parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
  parameter int DEPTH        = DEF_DEPTH,
  parameter int AW           = $clog2(DEPTH)
) (
  input  logic                    clock,
  input  logic                    we,
  input  logic [AW-1:0]           waddr,
  input  logic [SAMPLE_WIDTH-1:0] wdata,
  input  logic [AW-1:0]           raddr,
  output logic [SAMPLE_WIDTH-1:0] rdata
);

  logic [SAMPLE_WIDTH-1:0] mem [DEPTH];

  // Write port and synchronous read; contents are don't-care after reset.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/capture_buffer.sv
// capture_buffer: circular sample store with post-trigger fill and
// newest-first byte-serial readout toward the UART mux.
module capture_buffer
  import acsp_pkg::*;
#(
  parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
  parameter int DEPTH        = DEF_DEPTH
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    arm,
  input  logic [SAMPLE_WIDTH-1:0] data_in,
  input  logic                    valid_in,
  input  logic                    run,
  input  logic [15:0]             delay_count,
  input  logic [15:0]             read_count,
  input  logic                    tx_busy,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  output logic                    capturing,
  output logic                    done
);

  localparam int BPS = bytes_per(SAMPLE_WIDTH);
  localparam int AW  = $clog2(DEPTH);
  localparam int PW  = BPS * 8;
  localparam int BW  = (BPS > 1) ? $clog2(BPS) : 1;

  localparam logic [AW:0]   FULL     = (AW + 1)'(DEPTH);
  localparam logic [BW-1:0] LAST_IDX = BW'(BPS - 1);

  cap_state_t state_q, state_d;
  rd_phase_t  phase_q, phase_d;

  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]             fill_q, fill_d;
  logic [15:0]             post_cnt_q, post_cnt_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [15:0]             n_q, n_d;
  logic [SAMPLE_WIDTH-1:0] word_q, word_d;
  logic [BW-1:0]           byte_idx_q, byte_idx_d;
  logic [7:0]              tx_data_q, tx_data_d;
  logic                    tx_valid_q, tx_valid_d;
  logic                    done_q, done_d;

  logic                    we;
  logic                    wr_fire;
  logic                    go_read;
  logic [15:0]             fill16;
  logic [SAMPLE_WIDTH-1:0] rd_data;
  logic [PW-1:0]           word_pad;
  logic [7:0]              cur_byte;

  sample_ram #(
    .SAMPLE_WIDTH (SAMPLE_WIDTH),
    .DEPTH        (DEPTH),
    .AW           (AW)
  ) u_ram (
    .clock (clock),
    .we    (we),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  assign word_pad  = PW'(word_q);
  assign cur_byte  = 8'(word_pad >> {byte_idx_q, 3'b000});
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign done      = done_q;
  assign capturing = (state_q == CAP_ARMED) ||
                     (state_q == CAP_POST);

  // Next-state: capture, trigger hand-off, readout setup and byte pacing.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    wr_ptr_d   = wr_ptr_q;
    fill_d     = fill_q;
    post_cnt_d = post_cnt_q;
    rd_ptr_d   = rd_ptr_q;
    n_d        = n_q;
    word_d     = word_q;
    byte_idx_d = byte_idx_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = 1'b0;
    done_d     = done_q;
    we         = 1'b0;
    wr_fire    = 1'b0;
    go_read    = 1'b0;
    fill16     = '0;

    if (arm) begin
      state_d  = CAP_ARMED;
      wr_ptr_d = '0;
      fill_d   = '0;
      done_d   = 1'b0;
    end else begin
      unique case (state_q)
        CAP_IDLE: begin
        end
        CAP_ARMED: begin
          wr_fire = valid_in;
          if (run) begin
            state_d    = CAP_POST;
            post_cnt_d = '0;
          end
        end
        CAP_POST: begin
          // A zero delay hands off at once; no post sample is taken.
          if (delay_count == 16'd0) begin
            go_read = 1'b1;
          end else if (valid_in) begin
            wr_fire    = 1'b1;
            post_cnt_d = post_cnt_q + 16'd1;
            go_read    = (post_cnt_d == delay_count);
          end
        end
        CAP_READ: begin
          unique case (phase_q)
            RD_ISSUE: phase_d = RD_LATCH;
            RD_LATCH: begin
              word_d     = rd_data;
              byte_idx_d = '0;
              phase_d    = RD_SEND;
            end
            RD_SEND: begin
              if (!tx_busy) begin
                tx_valid_d = 1'b1;
                tx_data_d  = cur_byte;
                state_d    = CAP_WAIT_TX;
              end
            end
            default: phase_d = RD_ISSUE;
          endcase
        end
        CAP_WAIT_TX: begin
          // tx_valid_q marks the strobe cycle, before the UART raises busy.
          if (!tx_valid_q && !tx_busy) begin
            if (byte_idx_q != LAST_IDX) begin
              byte_idx_d = byte_idx_q + 1'b1;
              state_d    = CAP_READ;
              phase_d    = RD_SEND;
            end else begin
              rd_ptr_d = rd_ptr_q - 1'b1;
              n_d      = n_q - 16'd1;
              if (n_q == 16'd1) begin
                state_d = CAP_IDLE;
                done_d  = 1'b1;
              end else begin
                state_d = CAP_READ;
                phase_d = RD_ISSUE;
              end
            end
          end
        end
        default: state_d = CAP_IDLE;
      endcase

      if (wr_fire) begin
        we       = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (fill_q != FULL) begin
          fill_d = fill_q + 1'b1;
        end
      end

      // Readout starts at the newest stored sample, clipped to fill.
      if (go_read) begin
        fill16   = 16'(fill_d);
        rd_ptr_d = wr_ptr_d - 1'b1;
        n_d      = (read_count < fill16) ? read_count : fill16;
        if (n_d == 16'd0) begin
          state_d = CAP_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = CAP_READ;
          phase_d = RD_ISSUE;
        end
      end
    end
  end

  // State, pointer, counter and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= CAP_IDLE;
      phase_q    <= RD_ISSUE;
      wr_ptr_q   <= '0;
      fill_q     <= '0;
      post_cnt_q <= '0;
      rd_ptr_q   <= '0;
      n_q        <= '0;
      word_q     <= '0;
      byte_idx_q <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      wr_ptr_q   <= wr_ptr_d;
      fill_q     <= fill_d;
      post_cnt_q <= post_cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      n_q        <= n_d;
      word_q     <= word_d;
      byte_idx_q <= byte_idx_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      done_q     <= done_d;
    end
  end

endmodule
